// File: rtl/pe_operand_collector.sv
// pe_operand_collector: pairs A/B operands (a_*/b_* valid/ready in), drives the external half_adder (add_*), registers {carry,sum} in a valid/ready slot (res_*), clear flushes, op_count counts fires
module pe_operand_collector #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_on,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_carry,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_valid,
  input  logic             res_ready,
  input  logic             clear,
  output logic [15:0]      op_count
);
  logic             a_full_q, a_full_d, b_full_q, b_full_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             res_valid_q, res_valid_d, res_carry_q, res_carry_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             fire, a_acc, b_acc;
  always_comb begin
    fire        = a_full_q && b_full_q && (!res_valid_q || res_ready) && !clear;
    a_ready     = rst_n && !clear && (!a_full_q || fire);
    b_ready     = rst_n && !clear && (!b_full_q || fire);
    a_acc       = a_valid && a_ready;
    b_acc       = b_valid && b_ready;
    a_full_d    = clear ? 1'b0 : a_acc ? 1'b1 : fire ? 1'b0 : a_full_q;
    b_full_d    = clear ? 1'b0 : b_acc ? 1'b1 : fire ? 1'b0 : b_full_q;
    a_d         = a_acc ? a_data : a_q;
    b_d         = b_acc ? b_data : b_q;
    res_valid_d = clear ? 1'b0 : fire ? 1'b1 : res_ready ? 1'b0 : res_valid_q;
    res_data_d  = fire ? add_sum : res_data_q;
    res_carry_d = fire ? add_carry : res_carry_q;
    op_count_d  = fire ? op_count_q + 16'd1 : op_count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full_q    <= 1'b0;
      b_full_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      a_full_q    <= a_full_d;
      b_full_q    <= b_full_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      op_count_q  <= op_count_d;
    end
  end
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_on    = fire;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_valid = res_valid_q;
  assign op_count  = op_count_q;
endmodule

// File: doc/pe_operand_collector.md
# pe_operand_collector

Operand staging and result register for the tile's half_adder datapath. Collects operand A and operand B from two independent valid/ready channels and holds each until its partner arrives. When both are present and the output slot can take a result, it drives the adder with `add_on` asserted and registers `{carry, sum}` into an output slot with valid/ready handshake. Sits between the tile's input routing muxes and the next pipeline hop, and owns the adder's `on_off` enable.

## Interface
- `WIDTH`, 16: operand, adder and result data width.

- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `a_data`  in  WIDTH: operand A payload.
- `a_valid`  in  1: operand A offered.
- `a_ready`  out  1: operand A accepted when `a_valid && a_ready`.
- `b_data`  in  WIDTH: operand B payload.
- `b_valid`  in  1: operand B offered.
- `b_ready`  out  1: operand B accepted when `b_valid && b_ready`.
- `add_a`  out  WIDTH: to adder input a; always the A holding register.
- `add_b`  out  WIDTH: to adder input b; always the B holding register.
- `add_on`  out  1: to adder on_off; equals `fire`.
- `add_sum`  in  WIDTH: adder sum output.
- `add_carry`  in  1: adder carry output.
- `res_data`  out  WIDTH: registered sum.
- `res_carry`  out  1: registered carry.
- `res_valid`  out  1: result slot occupied.
- `res_ready`  in  1: downstream takes result when `res_valid && res_ready`.
- `clear`  in  1: synchronous flush of operands and result.
- `op_count`  out  16: number of fires since reset, wraps.

## Operation
- State per operand: holding register plus full flag (`a_full`, `b_full`). One result slot (`res_valid`, `res_data`, `res_carry`).
- `slot_free = !res_valid || res_ready`.
- `fire = a_full && b_full && slot_free && !clear`.
- `a_ready = !clear && (!a_full || fire)`. `b_ready` is defined the same way with B. This gives full throughput, one result per cycle; the combinational path from `res_ready` to `a_ready`/`b_ready` is intentional.
- On an A accept: load `a_data` and set `a_full`. On a fire without a new accept: clear `a_full`. On a fire with a new accept in the same cycle: reload, and `a_full` stays 1. B follows the same rules.
- On fire: `res_data <= add_sum`, `res_carry <= add_carry`, `res_valid <= 1`, `op_count <= op_count + 1` (mod 2^16).
- If there is no fire and `res_valid && res_ready`: `res_valid <= 0`. `res_data` and `res_carry` keep their last value.
- While `res_valid && !res_ready`: `res_data` and `res_carry` are held stable and no fire occurs.
- `add_on` is 0 whenever not firing. The adder then outputs zero, and the block ignores `add_sum` and `add_carry`.
- `clear` has priority over accept and fire. Next cycle: `a_full`, `b_full` and `res_valid` are 0, while the data registers and `op_count` are unchanged.
- The arithmetic is the adder's: sum = (A + B) mod 2^WIDTH, carry = bit WIDTH of the unsigned sum.

## Timing
- Reset values: all flags 0; `a_ready`, `b_ready`, `res_valid`, `add_on` 0 during reset; `res_data`, `res_carry`, holding registers and `op_count` 0.
- After reset deasserts: `a_ready` and `b_ready` are 1 in the first cycle.
- Latency: both operands accepted at edge N, fire in cycle N+1, `res_valid` = 1 after edge N+1. Accept-to-result is 2 cycles.
- Skewed arrival: an operand waiting for its partner is held indefinitely. The fire occurs in the cycle after the later operand is accepted.
- Backpressure: with both operands full and the slot blocked, `a_ready` and `b_ready` are 0. Upstream stalls with no loss.
- Reset asserted mid-operation clears everything immediately (asynchronous). A partially collected pair is discarded.

## Test plan
- Reset, then A=0x0003 and B=0x0004 in the same cycle with `res_ready`=1 -> `add_on`=1 exactly one cycle; after 2 cycles `res_data`=0x0007, `res_carry`=0, `op_count`=1.
- A=0xFFFF, B=0x0001 -> `res_data`=0x0000, `res_carry`=1; A=0x8000, B=0x8000 -> `res_data`=0x0000, `res_carry`=1.
- A sent 5 cycles before B=0x0010 (A=0x0020) -> no `add_on` until the cycle after B is accepted, then `res_data`=0x0030; `a_ready`=0 while waiting.
- `res_ready`=0 with 3 pairs queued -> one result held stable, both operands full, `a_ready`=`b_ready`=0; release `res_ready` -> 3 results in order on consecutive cycles.
- `clear` pulsed with A full and `res_valid`=1 -> next cycle `res_valid`=0, `a_full`=0, no fire, `op_count` unchanged.
- 65537 back-to-back pairs streamed -> `op_count` wraps to 0x0001; `res_valid` stays high with a new value every cycle.
